pipeline_hazard_ctrl: RTL and testbench

//   Hazard and sequencing controller for the 5-stage MIPS pipeline datapath.

---
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: forwarding, load-use and
// branch-operand stalls, jump/branch flush, and debug halt. PERF_COUNTERS_EN enables the counters.
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_equal,
    input  logic             id_jump,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_dst,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             hazard_sel,
    output logic             if_id_flush,
    output logic [1:0]       pc_src,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    // First bubble is issued from RUN, the remainder from STALL.
    localparam logic [2:0] LOAD_CNT = 3'(STALL_CYCLES - 1);

    state_t     state;
    logic [2:0] stall_cnt;
    logic       lu, bh;

    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic mw, input logic [4:0] md,
                                           input logic ww, input logic [4:0] wd);
        if (mw && md != 5'd0 && md == r)      return 2'b01;
        else if (ww && wd != 5'd0 && wd == r) return 2'b10;
        else                                  return 2'b00;
    endfunction

    function automatic logic hit(input logic [4:0] r,
                                 input logic ew, input logic [4:0] ed,
                                 input logic mw, input logic [4:0] md);
        return (r != 5'd0) && ((ew && ed == r) || (mw && md == r));
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            fwd_a = fwd_sel(ex_rs, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
            fwd_b = fwd_sel(ex_rt, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
        end
    end

    assign lu = ex_mem_read && (ex_dst != 5'd0) &&
                ((ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
    assign bh = id_branch &&
                (hit(id_rs, ex_reg_write, ex_dst, mem_reg_write, mem_rd) ||
                 hit(id_rt, ex_reg_write, ex_dst, mem_reg_write, mem_rd));

    // Outputs must react to hazards in the same cycle, so they decode state + inputs.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        hazard_sel  = 1'b0;
        if_id_flush = 1'b0;
        pc_src      = 2'b00;
        halt_ack    = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (!(lu || bh)) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        hazard_sel  = 1'b1;
                        if (id_jump) begin
                            pc_src      = 2'b10;
                            if_id_flush = 1'b1;
                        end else if (id_branch && id_equal) begin
                            pc_src      = 2'b01;
                            if_id_flush = 1'b1;
                        end
                    end
                end
                HALT:    halt_ack = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (lu) begin
                        stall_cnt <= LOAD_CNT;
                        if (LOAD_CNT != 3'd0) state <= STALL;
                    end else if (!bh && !if_id_flush && halt_req) begin
                        state <= HALT;
                    end
                end
                STALL: begin
                    stall_cnt <= stall_cnt - 3'd1;
                    if (stall_cnt == 3'd1) state <= RUN;
                end
                HALT: begin
                    if (!halt_req) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!hazard_sel && state != HALT && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
            if (if_id_flush && flush_q != '1)                  flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (STALL_CYCLES 1 and 3) share inputs;
// the driver queues hand-computed expectations, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_rd, wb_rd;
    logic       id_uses_rt, id_branch, id_equal, id_jump;
    logic       ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write, halt_req;

    logic        pw1, iw1, hs1, fl1, ha1, pw3, iw3, hs3, fl3, ha3;
    logic [1:0]  ps1, fa1, fb1, ps3, fa3, fb3;
    logic [15:0] sc1, fc1, sc3, fc3;

    pipeline_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_equal(id_equal), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .halt_req(halt_req),
        .pc_write(pw1), .if_id_write(iw1), .hazard_sel(hs1), .if_id_flush(fl1),
        .pc_src(ps1), .fwd_a(fa1), .fwd_b(fb1), .halt_ack(ha1),
        .stall_count(sc1), .flush_count(fc1));

    pipeline_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_equal(id_equal), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .halt_req(halt_req),
        .pc_write(pw3), .if_id_write(iw3), .hazard_sel(hs3), .if_id_flush(fl3),
        .pc_src(ps3), .fwd_a(fa3), .fwd_b(fb3), .halt_ack(ha3),
        .stall_count(sc3), .flush_count(fc3));

    // {pc_write, if_id_write, hazard_sel, if_id_flush, pc_src, fwd_a, fwd_b, halt_ack}
    logic [10:0] o1, o3;
    assign o1 = {pw1, iw1, hs1, fl1, ps1, fa1, fb1, ha1};
    assign o3 = {pw3, iw3, hs3, fl3, ps3, fa3, fb3, ha3};

    localparam logic [10:0] NRM = 11'b1110_00_00_00_0;
    localparam logic [10:0] STL = 11'b0000_00_00_00_0;
    localparam logic [10:0] HLT = 11'b0000_00_00_00_1;

    typedef struct {
        string       name;
        bit          d3;
        logic [10:0] o;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cnt(input int x);
`ifdef PERF_COUNTERS_EN
        return 16'(x);
`else
        return (x == -1) ? 16'hffff : 16'd0;
`endif
    endfunction

    function automatic logic [10:0] ov(input bit pw, input bit iw, input bit hs, input bit fl,
                                       input logic [1:0] ps, input logic [1:0] fa,
                                       input logic [1:0] fb, input bit ha);
        return {pw, iw, hs, fl, ps, fa, fb, ha};
    endfunction

    task automatic push(input string n, input bit d3, input logic [10:0] o,
                        input int sc, input int fc);
        exp_t e;
        e.name = n; e.d3 = d3; e.o = o; e.sc = cnt(sc); e.fc = cnt(fc);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_rd, wb_rd} = '0;
        {id_uses_rt, id_branch, id_equal, id_jump} = '0;
        {ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write, halt_req} = '0;
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1; idle();
        tick(); rst = 1'b0;
    endtask

    task automatic load_use();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd2;
        id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [10:0] ao;
            logic [15:0] asc, afc;
            e   = q.pop_front();
            ao  = e.d3 ? o3  : o1;
            asc = e.d3 ? sc3 : sc1;
            afc = e.d3 ? fc3 : fc1;
            checks++;
            if (ao !== e.o || asc !== e.sc || afc !== e.fc) begin
                errors++;
                $display("FAIL %s: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d",
                         e.name, ao, asc, afc, e.o, e.sc, e.fc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        // reset forces everything low even with forwarding-worthy inputs
        tick(); mem_reg_write = 1'b1; mem_rd = 5'd5; ex_rs = 5'd5;
        push("reset_u1", 0, STL, 0, 0);
        push("reset_u3", 1, STL, 0, 0);
        tick(); rst = 1'b0; idle();
        push("run_idle", 0, NRM, 0, 0);

        // forwarding
        tick(); mem_reg_write = 1; wb_reg_write = 1; mem_rd = 5; wb_rd = 5; ex_rs = 5;
        push("fwd_mem_prio", 0, ov(1,1,1,0,2'b00,2'b01,2'b00,0), 0, 0);
        tick(); mem_rd = 0; ex_rs = 0; ex_rt = 5;
        push("fwd_r0", 0, ov(1,1,1,0,2'b00,2'b00,2'b10,0), 0, 0);
        tick(); mem_reg_write = 0; mem_rd = 5; ex_rs = 5; ex_rt = 5;
        push("fwd_wb", 0, ov(1,1,1,0,2'b00,2'b10,2'b10,0), 0, 0);

        // load-use, one bubble
        tick(); idle(); load_use();
        push("lu_stall", 0, STL, 0, 0);
        tick(); idle(); id_rs = 2; id_rt = 4; id_uses_rt = 1; mem_rd = 2; mem_reg_write = 1;
        push("lu_resume", 0, NRM, 1, 0);
        tick(); idle(); ex_rs = 2; ex_rt = 4; wb_rd = 2; wb_reg_write = 1;
        push("lu_fwd", 0, ov(1,1,1,0,2'b00,2'b10,2'b00,0), 1, 0);
        tick(); idle(); ex_mem_read = 1; ex_dst = 4; id_rs = 2; id_rt = 4;
        push("lu_no_rt", 0, NRM, 1, 0);

        // load-use, three bubbles, jump ignored mid-stall
        do_reset();
        tick(); idle(); load_use();
        push("lu3_b1", 1, STL, 0, 0);
        tick(); idle(); id_jump = 1;
        push("lu3_b2_jump_ign", 1, STL, 1, 0);
        tick();
        push("lu3_b3", 1, STL, 2, 0);
        tick();
        push("lu3_jump_after", 1, ov(1,1,1,1,2'b10,2'b00,2'b00,0), 3, 0);
        tick(); idle();
        push("lu3_fc", 1, NRM, 3, 1);

        // branch / jump flush
        do_reset();
        tick(); idle(); id_branch = 1; id_equal = 1; id_rs = 1; id_rt = 1;
        push("beq_taken", 0, ov(1,1,1,1,2'b01,2'b00,2'b00,0), 0, 0);
        tick(); idle();
        push("beq_flush_once", 0, NRM, 0, 1);
        tick(); id_branch = 1; id_equal = 1; id_jump = 1;
        push("jump_prio", 0, ov(1,1,1,1,2'b10,2'b00,2'b00,0), 0, 1);
        tick(); idle(); id_branch = 1;
        push("beq_not_taken", 0, NRM, 0, 2);

        // branch-operand hazards
        tick(); idle(); id_branch = 1; id_equal = 1; id_rs = 7; id_rt = 3;
        ex_reg_write = 1; ex_dst = 7;
        push("bh_ex", 0, STL, 0, 2);
        tick(); ex_reg_write = 0; ex_dst = 0; mem_rd = 7; mem_reg_write = 1;
        push("bh_mem", 0, STL, 1, 2);
        tick(); mem_rd = 0; mem_reg_write = 0; wb_rd = 7; wb_reg_write = 1;
        push("bh_resolve", 0, ov(1,1,1,1,2'b01,2'b00,2'b00,0), 2, 2);
        tick(); idle();
        push("bh_fc", 0, NRM, 2, 3);

        // halt deferred through STALL, then reset out of HALT
        do_reset();
        tick(); idle(); load_use(); halt_req = 1;
        push("halt_lu", 1, STL, 0, 0);
        tick(); idle(); halt_req = 1;
        push("halt_in_stall", 1, STL, 1, 0);
        tick();
        push("halt_in_stall2", 1, STL, 2, 0);
        tick();
        push("halt_defer_run", 1, NRM, 3, 0);
        tick();
        push("halt_ack", 1, HLT, 3, 0);
        tick();
        push("halt_no_count", 1, HLT, 3, 0);
        tick(); halt_req = 0;
        push("halt_release", 1, HLT, 3, 0);
        tick();
        push("halt_off", 1, NRM, 3, 0);
        tick(); halt_req = 1;
        push("halt_again", 1, NRM, 3, 0);
        tick();
        push("halt_ack2", 1, HLT, 3, 0);
        tick(); rst = 1; mem_reg_write = 1; mem_rd = 5; ex_rs = 5;
        push("rst_in_halt", 1, STL, 0, 0);
        tick(); rst = 0; idle();
        push("run_after_rst", 1, NRM, 0, 0);

        tick(); tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
